// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: one-vote-per-ID ballot arming, saturating per-candidate tallies and result readout
module evm_ballot_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int ID_W        = 5,
  parameter int ARM_TIMEOUT = 255,
  parameter int LED_HOLD    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                id_valid,
  input  logic [ID_W-1:0]     voter_id,
  input  logic [NUM_CAND-1:0] vote_btn,
  input  logic [3:0]          sel_cand,
  output logic                green_led,
  output logic                red_led,
  output logic                vote_ack,
  output logic [CNT_W-1:0]    result_count,
  output logic [CNT_W-1:0]    total_count
);
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam int HW = $clog2(LED_HOLD + 1);
  typedef enum logic [1:0] {IDLE, ARMED, REJECT} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tmr;
  logic [HW-1:0] r_hold;
  logic [ID_W-1:0] r_id;
  logic [(1<<ID_W)-1:0] r_used;
  logic [CNT_W-1:0] r_cnt [NUM_CAND];
  logic [CNT_W-1:0] r_res, r_total, w_sel;
  logic r_green, r_red, r_ack, w_onehot, w_vote;
  assign w_onehot = (|vote_btn) && !(|(vote_btn & (vote_btn - NUM_CAND'(1))));
  always_comb begin
    w_next = r_state;
    w_vote = 1'b0;
    case (r_state)
      IDLE:    if (!mode && id_valid) w_next = r_used[voter_id] ? REJECT : ARMED;
      ARMED: begin
        // a clean press beats a same-cycle timeout; switching to result mode aborts outright
        w_vote = !mode && w_onehot;
        if (mode || w_vote || r_tmr == TW'(1)) w_next = IDLE;
      end
      REJECT:  if (r_hold == HW'(1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CAND; i++) if (sel_cand == 4'(i)) w_sel = r_cnt[i];
  end
  always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmr   <= '0;
      r_hold  <= '0;
      r_id    <= '0;
      r_used  <= '0;
      r_total <= '0;
      r_res   <= '0;
      r_green <= 1'b0;
      r_red   <= 1'b0;
      r_ack   <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
    end else begin
      r_green <= w_next == ARMED;
      r_red   <= w_next == REJECT;
      r_ack   <= w_vote;
      r_res   <= mode ? w_sel : '0;
      if (r_state == IDLE) begin
        r_id   <= voter_id;
        r_tmr  <= TW'(ARM_TIMEOUT);
        r_hold <= HW'(LED_HOLD);
      end else begin
        r_tmr  <= r_tmr - TW'(1);
        r_hold <= r_hold - HW'(1);
      end
      if (w_vote) begin
        r_used[r_id] <= 1'b1;
        r_total      <= &r_total ? r_total : r_total + CNT_W'(1);
        for (int i = 0; i < NUM_CAND; i++)
          if (vote_btn[i] && !(&r_cnt[i])) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end
  assign green_led    = r_green;
  assign red_led      = r_red;
  assign vote_ack     = r_ack;
  assign result_count = r_res;
  assign total_count  = r_total;
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// tb_evm_ballot_ctrl: directed checks of arming, rejection, timeout, abort, reset and saturation
module tb_evm_ballot_ctrl;
  logic clock = 1'b0, reset = 1'b1, mode = 1'b0, id_valid = 1'b0;
  logic [4:0] voter_id = '0;
  logic [3:0] vote_btn = '0, sel_cand = '0;
  logic green_led, red_led, vote_ack, s_green, s_red, s_ack;
  logic [7:0] result_count, total_count;
  logic [1:0] s_result, s_total;
  int n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  evm_ballot_ctrl #(.NUM_CAND(4), .CNT_W(8), .ID_W(5), .ARM_TIMEOUT(10), .LED_HOLD(4)) dut (
    .clock(clock), .reset(reset), .mode(mode), .id_valid(id_valid), .voter_id(voter_id),
    .vote_btn(vote_btn), .sel_cand(sel_cand), .green_led(green_led), .red_led(red_led),
    .vote_ack(vote_ack), .result_count(result_count), .total_count(total_count));

  evm_ballot_ctrl #(.NUM_CAND(4), .CNT_W(2), .ID_W(5), .ARM_TIMEOUT(10), .LED_HOLD(4)) dut_s (
    .clock(clock), .reset(reset), .mode(mode), .id_valid(id_valid), .voter_id(voter_id),
    .vote_btn(vote_btn), .sel_cand(sel_cand), .green_led(s_green), .red_led(s_red),
    .vote_ack(s_ack), .result_count(s_result), .total_count(s_total));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic present_id(input logic [4:0] id);
    @(negedge clock);
    id_valid = 1'b1;
    voter_id = id;
    @(negedge clock);
    id_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clock);
    vote_btn = b;
    @(negedge clock);
    vote_btn = '0;
  endtask

  task automatic test_reset;
    tick(2);
    reset = 1'b0;
    tick(1);
    n_vec++; if (green_led !== 1'b0) begin n_err++; $display("FAIL rst_green got %0b want 0", green_led); end
    n_vec++; if (red_led !== 1'b0) begin n_err++; $display("FAIL rst_red got %0b want 0", red_led); end
    n_vec++; if (vote_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %0b want 0", vote_ack); end
    n_vec++; if (result_count !== 8'd0) begin n_err++; $display("FAIL rst_result got %0d want 0", result_count); end
    n_vec++; if (total_count !== 8'd0) begin n_err++; $display("FAIL rst_total got %0d want 0", total_count); end
  endtask

  task automatic test_vote;
    present_id(5'd3);
    n_vec++; if (green_led !== 1'b1) begin n_err++; $display("FAIL vote_armed got %0b want 1", green_led); end
    tick(1);
    press(4'b0010);
    n_vec++; if (vote_ack !== 1'b1) begin n_err++; $display("FAIL vote_ack got %0b want 1", vote_ack); end
    n_vec++; if (green_led !== 1'b0) begin n_err++; $display("FAIL vote_green_off got %0b want 0", green_led); end
    n_vec++; if (total_count !== 8'd1) begin n_err++; $display("FAIL vote_total got %0d want 1", total_count); end
    tick(1);
    n_vec++; if (vote_ack !== 1'b0) begin n_err++; $display("FAIL vote_ack_pulse got %0b want 0", vote_ack); end
    mode = 1'b1;
    sel_cand = 4'd1;
    tick(1);
    n_vec++; if (result_count !== 8'd1) begin n_err++; $display("FAIL result_c1 got %0d want 1", result_count); end
    sel_cand = 4'd0;
    tick(1);
    n_vec++; if (result_count !== 8'd0) begin n_err++; $display("FAIL result_c0 got %0d want 0", result_count); end
    mode = 1'b0;
    tick(1);
    n_vec++; if (result_count !== 8'd0) begin n_err++; $display("FAIL result_mode0 got %0d want 0", result_count); end
  endtask

  task automatic test_reject;
    int n_red = 0, n_ack = 0;
    present_id(5'd3);
    for (int k = 0; k < 10; k++) begin
      if (red_led) n_red++;
      if (vote_ack) n_ack++;
      vote_btn = (k == 0) ? 4'b0001 : 4'b0000;
      tick(1);
    end
    n_vec++; if (n_red !== 4) begin n_err++; $display("FAIL reject_hold got %0d want 4", n_red); end
    n_vec++; if (n_ack !== 0) begin n_err++; $display("FAIL reject_ack got %0d want 0", n_ack); end
    n_vec++; if (total_count !== 8'd1) begin n_err++; $display("FAIL reject_total got %0d want 1", total_count); end
    n_vec++; if (red_led !== 1'b0) begin n_err++; $display("FAIL reject_end got %0b want 0", red_led); end
  endtask

  task automatic test_multi_press;
    present_id(5'd7);
    press(4'b0110);
    n_vec++; if (vote_ack !== 1'b0) begin n_err++; $display("FAIL multi_ack got %0b want 0", vote_ack); end
    n_vec++; if (green_led !== 1'b1) begin n_err++; $display("FAIL multi_armed got %0b want 1", green_led); end
    press(4'b1000);
    n_vec++; if (vote_ack !== 1'b1) begin n_err++; $display("FAIL single_ack got %0b want 1", vote_ack); end
    n_vec++; if (total_count !== 8'd2) begin n_err++; $display("FAIL single_total got %0d want 2", total_count); end
    mode = 1'b1;
    sel_cand = 4'd3;
    tick(1);
    n_vec++; if (result_count !== 8'd1) begin n_err++; $display("FAIL result_c3 got %0d want 1", result_count); end
    mode = 1'b0;
    present_id(5'd7);
    n_vec++; if (red_led !== 1'b1) begin n_err++; $display("FAIL used7_red got %0b want 1", red_led); end
    tick(6);
  endtask

  task automatic test_timeout;
    int n_grn = 0;
    present_id(5'd9);
    for (int k = 0; k < 20; k++) begin
      if (green_led) n_grn++;
      tick(1);
    end
    n_vec++; if (n_grn !== 10) begin n_err++; $display("FAIL timeout_len got %0d want 10", n_grn); end
    n_vec++; if (total_count !== 8'd2) begin n_err++; $display("FAIL timeout_total got %0d want 2", total_count); end
    present_id(5'd9);
    n_vec++; if (green_led !== 1'b1) begin n_err++; $display("FAIL rearm9_green got %0b want 1", green_led); end
    n_vec++; if (red_led !== 1'b0) begin n_err++; $display("FAIL rearm9_red got %0b want 0", red_led); end
    tick(12);
  endtask

  task automatic test_abort_and_reset;
    present_id(5'd12);
    mode = 1'b1;
    sel_cand = 4'd4;
    tick(1);
    n_vec++; if (green_led !== 1'b0) begin n_err++; $display("FAIL abort_green got %0b want 0", green_led); end
    n_vec++; if (vote_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack got %0b want 0", vote_ack); end
    n_vec++; if (result_count !== 8'd0) begin n_err++; $display("FAIL result_oor got %0d want 0", result_count); end
    mode = 1'b0;
    tick(1);
    present_id(5'd12);
    n_vec++; if (green_led !== 1'b1) begin n_err++; $display("FAIL rearm12_green got %0b want 1", green_led); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_vec++; if (green_led !== 1'b0) begin n_err++; $display("FAIL midrst_green got %0b want 0", green_led); end
    n_vec++; if (total_count !== 8'd0) begin n_err++; $display("FAIL midrst_total got %0d want 0", total_count); end
    present_id(5'd7);
    n_vec++; if (green_led !== 1'b1) begin n_err++; $display("FAIL reuse7_green got %0b want 1", green_led); end
    mode = 1'b1;
    sel_cand = 4'd3;
    tick(1);
    n_vec++; if (result_count !== 8'd0) begin n_err++; $display("FAIL midrst_c3 got %0d want 0", result_count); end
    mode = 1'b0;
    tick(2);
  endtask

  task automatic test_saturate;
    int n_ack = 0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int id = 0; id < 5; id++) begin
      present_id(5'(id));
      press(4'b0001);
      if (s_ack) n_ack++;
    end
    n_vec++; if (n_ack !== 5) begin n_err++; $display("FAIL sat_acks got %0d want 5", n_ack); end
    n_vec++; if (s_total !== 2'd3) begin n_err++; $display("FAIL sat_total got %0d want 3", s_total); end
    n_vec++; if (total_count !== 8'd5) begin n_err++; $display("FAIL wide_total got %0d want 5", total_count); end
    mode = 1'b1;
    sel_cand = 4'd0;
    tick(1);
    n_vec++; if (s_result !== 2'd3) begin n_err++; $display("FAIL sat_c0 got %0d want 3", s_result); end
    n_vec++; if (result_count !== 8'd5) begin n_err++; $display("FAIL wide_c0 got %0d want 5", result_count); end
    mode = 1'b0;
    present_id(5'd4);
    n_vec++; if (s_red !== 1'b1) begin n_err++; $display("FAIL sat_used4 got %0b want 1", s_red); end
    tick(6);
  endtask

  initial begin
    test_reset();
    test_vote();
    test_reject();
    test_multi_press();
    test_timeout();
    test_abort_and_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
